video_pattern_source: RTL and testbench

AXI4-Stream video master that generates synthetic RGB test frames (solid, ramp, checkerboard, colour bars) with standard SOF/EOL sideband. It sits upstream of the barrel distortion correction path as its frame transmitter for bring-up and simulation. It honours full tready backpressure, so a downstream core can stall it arbitrarily. Checkerboard mode exists specifically to make geometric correction visible.

---
 rtl/video_pkg.sv | 45 ++++
 rtl/video_pattern_source_if.sv | 13 +
 rtl/video_pattern_pixel.sv | 41 ++++
 rtl/video_pattern_source.sv | 185 ++++++++++++++++++
 tb/tb_video_pattern_source.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared types and helpers for the synthetic video pattern source.
package video_pkg;

  typedef enum logic [1:0] {
    PatSolid   = 2'd0,
    PatRamp    = 2'd1,
    PatChecker = 2'd2,
    PatBars    = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StHblank,
    StVblank
  } state_e;

  // Bar colours as {R,G,B} full-scale enables.
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  function automatic int unsigned comp_width(int unsigned data_width);
    return data_width / 3;
  endfunction

  function automatic logic [2:0] bar_rgb(logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_pattern_source_if.sv
// AXI4-Stream video channel carrying packed {R,G,B} pixels with SOF (tuser) / EOL (tlast).
interface video_pattern_source_if #(
  parameter int unsigned DATA_WIDTH = 24
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/video_pattern_pixel.sv
// Combinational pixel generator: maps (x, y, bar index, pattern) to a packed {R,G,B} pixel.
module video_pattern_pixel
  import video_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 24,
  parameter int unsigned           COORD_WIDTH = 16,
  parameter int unsigned           CHECK_SHIFT = 5,
  parameter logic [DATA_WIDTH-1:0] SOLID_COLOR = 24'h808080
) (
  input  logic [COORD_WIDTH-1:0] x,
  input  logic [COORD_WIDTH-1:0] y,
  input  logic [2:0]             bar,
  input  pattern_e               sel,
  output logic [DATA_WIDTH-1:0]  pixel
);

  localparam int unsigned C = comp_width(DATA_WIDTH);

  logic [C-1:0] ramp_c;
  logic         cell_odd;
  logic [2:0]   rgb;
  logic         unused_coord;

  assign ramp_c       = x[C-1:0];
  assign cell_odd     = x[CHECK_SHIFT] ^ y[CHECK_SHIFT];
  assign rgb          = bar_rgb(bar);
  assign unused_coord = ^{x, y};

  always_comb begin
    pixel = '0;
    unique case (sel)
      PatSolid:   pixel = SOLID_COLOR;
      PatRamp:    pixel = {3{ramp_c}};
      // Cell (0,0) is white so the top-left corner is easy to locate after correction.
      PatChecker: pixel = cell_odd ? '0 : '1;
      PatBars:    pixel = {{C{rgb[2]}}, {C{rgb[1]}}, {C{rgb[0]}}};
      default:    pixel = '0;
    endcase
  end

endmodule

// File: rtl/video_pattern_source.sv
// AXI4-Stream test-frame master with SOF/EOL sideband and full backpressure.
// Define VIDEO_PATGEN_BLANKING_EN to insert H_BLANK/V_BLANK idle cycles between lines/frames.
module video_pattern_source
  import video_pkg::*;
#(
  parameter int unsigned           WIDTH       = 1920,
  parameter int unsigned           HEIGHT      = 1080,
  parameter int unsigned           DATA_WIDTH  = 24,
  parameter int unsigned           COORD_WIDTH = 16,
  parameter int unsigned           CHECK_SHIFT = 5,
  parameter logic [DATA_WIDTH-1:0] SOLID_COLOR = 24'h808080
`ifdef VIDEO_PATGEN_BLANKING_EN
  ,
  parameter int unsigned           H_BLANK     = 16,
  parameter int unsigned           V_BLANK     = 64
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [1:0]                   pattern_sel,
  video_pattern_source_if.master       m_axis,
  output logic                         frame_done,
  output logic [15:0]                  frame_count
);

  localparam logic [COORD_WIDTH-1:0] XLast   = COORD_WIDTH'(WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] YLast   = COORD_WIDTH'(HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0] BarLast = COORD_WIDTH'(WIDTH / 8 - 1);

  state_e                  state_q, state_d;
  pattern_e                sel_q, sel_d;
  logic [COORD_WIDTH-1:0]  x_q, x_d, y_q, y_d, bpos_q, bpos_d;
  logic [2:0]              bar_q, bar_d;
  logic [DATA_WIDTH-1:0]   tdata_q, pixel;
  logic                    tvalid_q, tlast_q, tuser_q;
  logic                    frame_done_q;
  logic [15:0]             frame_count_q;
  logic                    xfer, frame_end, load;
`ifdef VIDEO_PATGEN_BLANKING_EN
  logic [15:0]             blank_q, blank_d;
`endif

  assign xfer = tvalid_q & m_axis.tready;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    x_d       = x_q;
    y_d       = y_q;
    bpos_d    = bpos_q;
    bar_d     = bar_q;
    frame_end = 1'b0;
`ifdef VIDEO_PATGEN_BLANKING_EN
    blank_d   = blank_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StActive;
          sel_d   = pattern_e'(pattern_sel);
          x_d     = '0;
          y_d     = '0;
          bpos_d  = '0;
          bar_d   = '0;
        end
      end
      StActive: begin
        if (xfer) begin
          if (x_q == XLast) begin
            x_d    = '0;
            bpos_d = '0;
            bar_d  = '0;
            if (y_q == YLast) begin
              frame_end = 1'b1;
              y_d       = '0;
              sel_d     = pattern_e'(pattern_sel);
              state_d   = enable ? StActive : StIdle;
`ifdef VIDEO_PATGEN_BLANKING_EN
              if (V_BLANK != 0) begin
                state_d = StVblank;
                blank_d = '0;
              end
`endif
            end else begin
              y_d = y_q + 1'b1;
`ifdef VIDEO_PATGEN_BLANKING_EN
              if (H_BLANK != 0) begin
                state_d = StHblank;
                blank_d = '0;
              end
`endif
            end
          end else begin
            x_d = x_q + 1'b1;
            // Bar index bumps every WIDTH/8 pixels; the last bar soaks up the remainder.
            if (bpos_q == BarLast && bar_q != 3'd7) begin
              bpos_d = '0;
              bar_d  = bar_q + 3'd1;
            end else begin
              bpos_d = bpos_q + 1'b1;
            end
          end
        end
      end
`ifdef VIDEO_PATGEN_BLANKING_EN
      StHblank: begin
        if (blank_q == 16'(H_BLANK - 1)) state_d = StActive;
        else                             blank_d = blank_q + 16'd1;
      end
      StVblank: begin
        if (blank_q == 16'(V_BLANK - 1)) begin
          state_d = enable ? StActive : StIdle;
          sel_d   = pattern_e'(pattern_sel);
        end else begin
          blank_d = blank_q + 16'd1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Output register reloads whenever a new beat is about to be presented.
  assign load = (state_d == StActive) && ((state_q != StActive) || xfer);

  video_pattern_pixel #(
    .DATA_WIDTH  (DATA_WIDTH),
    .COORD_WIDTH (COORD_WIDTH),
    .CHECK_SHIFT (CHECK_SHIFT),
    .SOLID_COLOR (SOLID_COLOR)
  ) u_pixel (
    .x     (x_d),
    .y     (y_d),
    .bar   (bar_d),
    .sel   (sel_d),
    .pixel (pixel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      sel_q         <= PatSolid;
      x_q           <= '0;
      y_q           <= '0;
      bpos_q        <= '0;
      bar_q         <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
`ifdef VIDEO_PATGEN_BLANKING_EN
      blank_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      x_q          <= x_d;
      y_q          <= y_d;
      bpos_q       <= bpos_d;
      bar_q        <= bar_d;
      tvalid_q     <= (state_d == StActive);
      frame_done_q <= frame_end;
      if (frame_end) frame_count_q <= frame_count_q + 16'd1;
      if (load) begin
        tdata_q <= pixel;
        tuser_q <= (x_d == '0) && (y_d == '0);
        tlast_q <= (x_d == XLast);
      end
`ifdef VIDEO_PATGEN_BLANKING_EN
      blank_q      <= blank_d;
`endif
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;
  assign frame_done    = frame_done_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_video_pattern_source.sv
// Directed bench for video_pattern_source on an 8x4 frame; honours VIDEO_PATGEN_BLANKING_EN.
module tb_video_pattern_source;

  localparam int W = 8;
  localparam int H = 4;
`ifdef VIDEO_PATGEN_BLANKING_EN
  localparam int HB = 2;
  localparam int VB = 3;
`else
  localparam int HB = 0;
  localparam int VB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        frame_done;
  logic [15:0] frame_count;
  int          checks = 0;
  int          errors = 0;

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  video_pattern_source_if #(.DATA_WIDTH(24)) axis ();

  video_pattern_source #(
    .WIDTH       (W),
    .HEIGHT      (H),
    .DATA_WIDTH  (24),
    .COORD_WIDTH (16),
    .CHECK_SHIFT (1),
    .SOLID_COLOR (24'h808080)
`ifdef VIDEO_PATGEN_BLANKING_EN
    ,
    .H_BLANK     (HB),
    .V_BLANK     (VB)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .m_axis      (axis),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int pat, input int x, input int y);
    logic [7:0] c;
    case (pat)
      0: return 24'h808080;
      1: begin
        c = 8'(x);
        return {c, c, c};
      end
      2: return ((((x >> 1) ^ (y >> 1)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
      default: return bar_tab[x];
    endcase
  endfunction

  // Waits (bounded) for one accepted beat, checking it every cycle it is presented.
  task automatic beat(input string tag, input logic [23:0] d, input logic u, input logic l,
                      input bit rnd, output int idle);
    bit done;
    bit stalled;
    int cyc;
    done = 0;
    stalled = 0;
    cyc = 0;
    idle = 0;
    while (!done && cyc < 200) begin
      if (stalled) chk({tag, " hold"}, 32'(axis.tvalid), 32'd1);
      if (axis.tvalid) begin
        chk({tag, " data"}, 32'(axis.tdata), 32'(d));
        chk({tag, " user"}, 32'(axis.tuser), 32'(u));
        chk({tag, " last"}, 32'(axis.tlast), 32'(l));
      end else begin
        idle++;
      end
      axis.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = axis.tvalid && !axis.tready;
      if (axis.tvalid && axis.tready) done = 1;
      tick();
      cyc++;
    end
    chk({tag, " timeout"}, 32'(done), 32'd1);
  endtask

  task automatic frame(input int pat, input int nbeats, input int drop_at, input int first_idle,
                       input bit rnd, input int sel_at, input int new_sel);
    int x;
    int y;
    int idle;
    string tag;
    for (int i = 0; i < nbeats; i++) begin
      x = i % W;
      y = i / W;
      tag = $sformatf("p%0d b%0d", pat, i);
      if (i == drop_at) enable = 1'b0;
      if (i == sel_at) pattern_sel = 2'(new_sel);
      beat(tag, exp_pix(pat, x, y), (i == 0), (x == W - 1), rnd, idle);
      if (i == 0) chk({tag, " idle"}, 32'(idle), 32'(first_idle));
      else        chk({tag, " idle"}, 32'(idle), (x == 0) ? 32'(HB) : 32'd0);
    end
  endtask

  initial begin
    axis.tready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    chk("rst tvalid", 32'(axis.tvalid), 32'd0);
    chk("rst tdata", 32'(axis.tdata), 32'd0);
    chk("rst tlast", 32'(axis.tlast), 32'd0);
    chk("rst tuser", 32'(axis.tuser), 32'd0);
    chk("rst frame_done", 32'(frame_done), 32'd0);
    chk("rst frame_count", 32'(frame_count), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle tvalid", 32'(axis.tvalid), 32'd0);

    // Ramp frame, enable dropped at beat 10: frame still completes, then idle.
    enable = 1'b1;
    pattern_sel = 2'd1;
    frame(1, 32, 10, 1, 0, -1, 0);
    chk("f1 frame_done", 32'(frame_done), 32'd1);
    chk("f1 frame_count", 32'(frame_count), 32'd1);
    chk("f1 tvalid after", 32'(axis.tvalid), 32'd0);
    repeat (VB + 2) tick();
    chk("f1 idle tvalid", 32'(axis.tvalid), 32'd0);
    chk("f1 done pulse", 32'(frame_done), 32'd0);

    // Checkerboard with 2-pixel cells.
    enable = 1'b1;
    pattern_sel = 2'd2;
    frame(2, 32, 1, 1, 0, -1, 0);
    chk("f2 frame_count", 32'(frame_count), 32'd2);
    repeat (VB + 2) tick();
    chk("f2 idle tvalid", 32'(axis.tvalid), 32'd0);

    // Colour bars with enable held; pattern_sel changes mid-frame, applies at next SOF.
    enable = 1'b1;
    pattern_sel = 2'd3;
    frame(3, 32, -1, 1, 0, 5, 1);
    chk("f3 frame_done", 32'(frame_done), 32'd1);
    chk("f3 frame_count", 32'(frame_count), 32'd3);

    // Back-to-back ramp frame under random backpressure.
    frame(1, 32, 1, VB, 1, -1, 0);
    chk("f4 frame_done", 32'(frame_done), 32'd1);
    chk("f4 frame_count", 32'(frame_count), 32'd4);
    axis.tready = 1'b1;
    repeat (VB + 2) tick();
    chk("f4 idle tvalid", 32'(axis.tvalid), 32'd0);

    // Reset while beat 13 of a solid frame is presented.
    enable = 1'b1;
    pattern_sel = 2'd0;
    frame(0, 13, -1, 1, 0, -1, 0);
    chk("f5 pre-rst tvalid", 32'(axis.tvalid), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst tvalid", 32'(axis.tvalid), 32'd0);
    chk("midrst frame_count", 32'(frame_count), 32'd0);
    chk("midrst frame_done", 32'(frame_done), 32'd0);
    chk("midrst tuser", 32'(axis.tuser), 32'd0);
    chk("midrst tdata", 32'(axis.tdata), 32'd0);
    rst = 1'b0;
    frame(0, 32, 1, 1, 0, -1, 0);
    chk("f6 frame_done", 32'(frame_done), 32'd1);
    chk("f6 frame_count", 32'(frame_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
